// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for a small multicycle RISC-V datapath. Each instruction
//   runs FETCH -> DECODE -> EXECUTE -> WRITEBACK (ALU ops, 4 cycles) or
//   FETCH -> DECODE -> BRANCH (BEQ, 3 cycles). Unsupported opcodes or ALU
//   functions park the FSM in HALT until reset.
//
//   Parameters:
//     COUNT_W      width of the retired-instruction counter (wraps)
//   Inputs:
//     clk          rising-edge clock
//     reset        asynchronous, active-high
//     enable       FSM advances only while high; state and count hold otherwise
//     instr[31:0]  instruction word (opcode [6:0], funct3 [14:12], funct7b5 [30])
//     zero         ALU zero flag, used as pc_src in BRANCH
//     step         (MCCTRL_STEP_EN only) FETCH advances on a registered 0->1 edge
//   Outputs:
//     ir_load, pc_en, pc_src, reg_write, alu_src, alu_control[2:0]
//     state[2:0]   current state code (debug display)
//     halted       high while in HALT
//     instr_count  retired-instruction count
//
//   Optional feature macro: MCCTRL_STEP_EN (single-step gating of FETCH).

module multicycle_control #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [31:0]        instr,
  input  logic               zero,
`ifdef MCCTRL_STEP_EN
  input  logic               step,
`endif
  output logic               ir_load,
  output logic               pc_en,
  output logic               pc_src,
  output logic               reg_write,
  output logic               alu_src,
  output logic [2:0]         alu_control,
  output logic [2:0]         state,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_BRANCH    = 3'd4,
    S_HALT      = 3'd7
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e               state_q, state_d;
  logic                 halted_q, halted_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [2:0]           alu_ctrl_q, alu_ctrl_d;
  logic                 alu_src_q, alu_src_d;

  // Instruction field decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       is_rtype;
  logic       is_itype;
  logic       is_beq;
  logic [2:0] alu_dec;
  logic       alu_legal;
  logic       step_fire;

  logic       unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr[31], instr[29:15], instr[11:7]};

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_itype = (opcode == OP_ITYPE);
  assign is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);

  always_comb begin
    alu_dec   = ALU_ADD;
    alu_legal = 1'b1;
    case (funct3)
      3'b000:  alu_dec = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b010:  alu_dec = ALU_SLT;
      default: alu_legal = 1'b0;
    endcase
  end

`ifdef MCCTRL_STEP_EN
  logic step_q, step_d;
  // Previous-cycle copy of step; FETCH fires only on a 0->1 transition.
  assign step_d    = step;
  assign step_fire = step && !step_q;
`else
  assign step_fire = 1'b1;
`endif

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_src_d  = alu_src_q;
    case (state_q)
      S_FETCH: begin
        if (enable && step_fire) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (enable) begin
          if (is_rtype || is_itype) state_d = S_EXECUTE;
          else if (is_beq)          state_d = S_BRANCH;
          else                      state_d = S_HALT;
        end
      end
      S_EXECUTE: begin
        if (enable) begin
          if (alu_legal) begin
            state_d    = S_WRITEBACK;
            // WRITEBACK replays the EXECUTE ALU setup from these copies
            alu_ctrl_d = alu_dec;
            alu_src_d  = is_itype;
          end else begin
            state_d = S_HALT;
          end
        end
      end
      S_WRITEBACK: begin
        if (enable) begin
          state_d = S_FETCH;
          count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_BRANCH: begin
        if (enable) begin
          state_d = S_FETCH;
          count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_HALT:  state_d = S_HALT;
      // Unused codes 5/6 escape to HALT regardless of enable
      default: state_d = S_HALT;
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      halted_q   <= 1'b0;
      count_q    <= '0;
      alu_ctrl_q <= ALU_ADD;
      alu_src_q  <= 1'b0;
`ifdef MCCTRL_STEP_EN
      step_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_src_q  <= alu_src_d;
`ifdef MCCTRL_STEP_EN
      step_q     <= step_d;
`endif
    end
  end

  // Moore control decode; zero reaches an output only via pc_src in BRANCH.
  // Write enables are gated by enable so a frozen state never repeats a write.
  always_comb begin
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: ir_load = step_fire;
      S_EXECUTE: begin
        if (alu_legal) begin
          alu_src     = is_itype;
          alu_control = alu_dec;
        end
      end
      S_WRITEBACK: begin
        reg_write   = enable;
        pc_en       = enable;
        alu_src     = alu_src_q;
        alu_control = alu_ctrl_q;
      end
      S_BRANCH: begin
        pc_en       = enable;
        pc_src      = zero;
        alu_control = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control (COUNT_W overridden to 4 so the
// counter wrap is reachable). Each table row is one clock cycle: inputs are
// applied after the falling edge and the outputs checked before the next
// rising edge.

module tb_multicycle_control;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [31:0]   instr;
  logic          zero;
  logic          ir_load, pc_en, pc_src, reg_write, alu_src, halted;
  logic [2:0]    alu_control, state;
  logic [CW-1:0] instr_count;
`ifdef MCCTRL_STEP_EN
  logic          step;
`endif

  multicycle_control #(.COUNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .instr       (instr),
    .zero        (zero),
`ifdef MCCTRL_STEP_EN
    .step        (step),
`endif
    .ir_load     (ir_load),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .alu_control (alu_control),
    .state       (state),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h40208133;
  localparam logic [31:0] I_ORI  = 32'h00A0E093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_ADDI = 32'h40000093;
  localparam logic [31:0] I_SLL  = 32'h002091B3;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;

  typedef struct {
    logic          en;
    logic [31:0]   instr;
    logic          zero;
    logic [2:0]    st;
    logic          ir, pe, ps, rw, as;
    logic [2:0]    ac;
    logic          h;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tv(input logic en, input logic [31:0] ins, input logic z,
                    input logic [2:0] st, input logic ir, input logic pe,
                    input logic ps, input logic rw, input logic as,
                    input logic [2:0] ac, input logic h, input logic [CW-1:0] cnt);
    vec_t v;
    v.en = en; v.instr = ins; v.zero = z; v.st = st; v.ir = ir; v.pe = pe;
    v.ps = ps; v.rw = rw; v.as = as; v.ac = ac; v.h = h; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Packed view: {state, ir_load, pc_en, pc_src, reg_write, alu_src, alu_control, halted, count}
  function automatic logic [15:0] obs();
    return {state, ir_load, pc_en, pc_src, reg_write, alu_src, alu_control, halted, instr_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_count", {{(32-CW){1'b0}}, instr_count}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    instr  = I_ADD;
    zero   = 1'b0;
`ifdef MCCTRL_STEP_EN
    step   = 1'b1;
`endif
    do_reset();

`ifndef MCCTRL_STEP_EN
    // en, instr, zero | st ir pe ps rw as ac h cnt
    tv(1, I_ADD, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 0);
    tv(1, I_ADD, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0);
    tv(1, I_ADD, 0, 2, 0, 0, 0, 0, 0, A_ADD, 0, 0);
    tv(1, I_ADD, 0, 3, 0, 1, 0, 1, 0, A_ADD, 0, 0);
    tv(1, I_SUB, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 1);
    tv(1, I_SUB, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 1);
    tv(1, I_SUB, 0, 2, 0, 0, 0, 0, 0, A_SUB, 0, 1);
    tv(1, I_SUB, 0, 3, 0, 1, 0, 1, 0, A_SUB, 0, 1);
    tv(1, I_ORI, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 2);
    tv(1, I_ORI, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 2);
    tv(1, I_ORI, 0, 2, 0, 0, 0, 0, 1, A_OR,  0, 2);
    tv(1, I_ORI, 0, 3, 0, 1, 0, 1, 1, A_OR,  0, 2);
    tv(1, I_BEQ, 1, 0, 1, 0, 0, 0, 0, A_ADD, 0, 3);
    tv(1, I_BEQ, 1, 1, 0, 0, 0, 0, 0, A_ADD, 0, 3);
    tv(1, I_BEQ, 1, 4, 0, 1, 1, 0, 0, A_SUB, 0, 3);
    tv(1, I_BEQ, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 4);
    tv(1, I_BEQ, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 4);
    tv(1, I_BEQ, 0, 4, 0, 1, 0, 0, 0, A_SUB, 0, 4);
    tv(1, I_SLT, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 5);
    tv(1, I_SLT, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 5);
    tv(1, I_SLT, 0, 2, 0, 0, 0, 0, 0, A_SLT, 0, 5);
    tv(1, I_SLT, 0, 3, 0, 1, 0, 1, 0, A_SLT, 0, 5);
    tv(1, I_AND, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 6);
    tv(1, I_AND, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 6);
    tv(1, I_AND, 0, 2, 0, 0, 0, 0, 0, A_AND, 0, 6);
    tv(1, I_AND, 0, 3, 0, 1, 0, 1, 0, A_AND, 0, 6);
    tv(1, I_ADDI, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 7);
    tv(1, I_ADDI, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 7);
    tv(1, I_ADDI, 0, 2, 0, 0, 0, 0, 1, A_ADD, 0, 7);
    tv(1, I_ADDI, 0, 3, 0, 1, 0, 1, 1, A_ADD, 0, 7);
    // enable dropped in EXECUTE for 5 cycles
    tv(1, I_ADD, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 8);
    tv(1, I_ADD, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 8);
    for (int i = 0; i < 5; i++) tv(0, I_ADD, 0, 2, 0, 0, 0, 0, 0, A_ADD, 0, 8);
    tv(1, I_ADD, 0, 2, 0, 0, 0, 0, 0, A_ADD, 0, 8);
    tv(1, I_ADD, 0, 3, 0, 1, 0, 1, 0, A_ADD, 0, 8);
    // enable dropped in WRITEBACK: writes suppressed, one write on resume
    tv(1, I_SUB, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 9);
    tv(1, I_SUB, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 9);
    tv(1, I_SUB, 0, 2, 0, 0, 0, 0, 0, A_SUB, 0, 9);
    tv(0, I_SUB, 0, 3, 0, 0, 0, 0, 0, A_SUB, 0, 9);
    tv(1, I_SUB, 0, 3, 0, 1, 0, 1, 0, A_SUB, 0, 9);
    // illegal funct3 in EXECUTE -> HALT, no write, sticky
    tv(1, I_SLL, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 10);
    tv(1, I_SLL, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 10);
    tv(1, I_SLL, 0, 2, 0, 0, 0, 0, 0, A_ADD, 0, 10);
    tv(1, I_SLL, 0, 7, 0, 0, 0, 0, 0, A_ADD, 1, 10);
    tv(0, I_ADD, 0, 7, 0, 0, 0, 0, 0, A_ADD, 1, 10);
    tv(1, I_ADD, 0, 7, 0, 0, 0, 0, 0, A_ADD, 1, 10);

    foreach (vecs[i]) begin
      enable = vecs[i].en;
      instr  = vecs[i].instr;
      zero   = vecs[i].zero;
      #1;
      check($sformatf("vec%0d", i), {16'd0, obs()},
            {16'd0, vecs[i].st, vecs[i].ir, vecs[i].pe, vecs[i].ps, vecs[i].rw,
             vecs[i].as, vecs[i].ac, vecs[i].h, vecs[i].cnt});
      @(negedge clk);
    end

    // Reset leaves HALT
    reset = 1'b1;
    #1;
    check("halt_reset_state", {29'd0, state}, 32'd0);
    check("halt_reset_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Opcode 0: FETCH, DECODE, HALT; HALT survives enable toggling
    enable = 1'b1;
    instr  = 32'h0000_0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("zero_op_halt_state", {29'd0, state}, 32'd7);
    check("zero_op_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      enable = i[0];
      @(negedge clk);
      #1;
      check($sformatf("halt_sticky%0d", i), {29'd0, state}, 32'd7);
    end
    enable = 1'b1;
    do_reset();

    // Reset asserted during WRITEBACK aborts the write
    instr = I_ADD;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("wb_before_reset", {30'd0, reg_write, state == 3'd3}, 32'd3);
    reset = 1'b1;
    #1;
    check("wb_reset_state", {29'd0, state}, 32'd0);
    check("wb_reset_rw", {31'd0, reg_write}, 32'd0);
    @(negedge clk);
    check("wb_reset_count", {{(32-CW){1'b0}}, instr_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("first_edge_fetch", {29'd0, state}, 32'd1);
    do_reset();

    // Counter wraps from all-ones to zero
    instr = I_BEQ;
    zero  = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      repeat (3) @(negedge clk);
      #1;
      check($sformatf("wrap_cnt%0d", i), {{(32-CW){1'b0}}, instr_count}, i % 16);
    end
`else
    // step held high: one instruction, then FETCH waits for a new step edge
    enable = 1'b1;
    instr  = I_ADD;
    #1;
    check("step_first_irload", {31'd0, ir_load}, 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("step_one_done_count", {{(32-CW){1'b0}}, instr_count}, 32'd1);
    check("step_hold_irload", {31'd0, ir_load}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("step_hold_state", {29'd0, state}, 32'd0);
    check("step_hold_count", {{(32-CW){1'b0}}, instr_count}, 32'd1);
    step = 1'b0;
    @(negedge clk);
    #1;
    check("step_low_state", {29'd0, state}, 32'd0);
    step = 1'b1;
    #1;
    check("step_rise_irload", {31'd0, ir_load}, 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("step_second_count", {{(32-CW){1'b0}}, instr_count}, 32'd2);
    check("step_second_state", {29'd0, state}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: COUNT_W, default 16, width of the retired-instruction counter.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: enable  input  1  FSM advances only when 1; when 0, state, counter and outputs are held.
REQ-005 Port: instr  input  32  instruction word from instruction memory; fields are opcode [6:0], funct3 [14:12], funct7b5 [30].
REQ-006 Port: zero  input  1  ALU Zero flag, sampled in BRANCH.
REQ-007 Port: ir_load  output  1  latches instr into the instruction register.
REQ-008 Port: pc_en  output  1  PC load enable.
REQ-009 Port: pc_src  output  1  0 selects PC+4, 1 selects the branch target.
REQ-010 Port: reg_write  output  1  register-bank write enable.
REQ-011 Port: alu_src  output  1  0 selects the register operand, 1 selects the sign-extended immediate.
REQ-012 Port: alu_control  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-013 Port: state  output  3  current state code, for 7-segment debug display.
REQ-014 Port: halted  output  1  high while in HALT.
REQ-015 Port: instr_count  output  COUNT_W  number of retired instructions.

Function
REQ-016 States and codes: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, BRANCH=4, HALT=7; codes 5 and 6 are unused, and reaching either forces HALT on the next edge.
REQ-017 FETCH: ir_load=1 for exactly one cycle; next state DECODE.
REQ-018 DECODE: instr is classified; opcode 0110011 (R-type) or 0010011 (I-type) goes to EXECUTE, opcode 1100011 with funct3=000 (BEQ) goes to BRANCH, anything else goes to HALT.
REQ-019 EXECUTE: alu_src=0 for R-type and 1 for I-type; alu_control is decoded from funct3 and funct7b5; next state WRITEBACK.
REQ-020 ALU decode: funct3 000 gives ADD, or SUB when R-type with funct7b5=1; 111 gives AND; 110 gives OR; 010 gives SLT.
REQ-021 ALU decode, illegal case: any other funct3 in EXECUTE sends the FSM to HALT with no write.
REQ-022 WRITEBACK: reg_write=1, pc_en=1, pc_src=0, and alu_control/alu_src hold their EXECUTE values; instr_count increments; next state FETCH.
REQ-023 BRANCH: alu_src=0, alu_control=SUB, pc_en=1, pc_src=zero, reg_write=0; instr_count increments; next state FETCH.
REQ-024 Latency: ALU instructions take 4 cycles; BEQ takes 3 cycles; all counts assume enable held at 1.
REQ-025 HALT: all enables are 0 and halted=1; HALT is sticky until reset, regardless of enable.
REQ-026 In every state not listed above, ir_load, pc_en, pc_src, reg_write and alu_src are 0 and alu_control=ADD.
REQ-027 instr_count wraps from all-ones to 0 without saturating.
REQ-028 Control outputs are Moore decodes of state and instr, with no combinational path from zero except through pc_src in BRANCH.
REQ-029 When enable falls mid-instruction, the FSM freezes in its current state with the outputs of that state; pc_en and reg_write are also forced to 0 while enable=0, so the frozen state causes no repeated writes.

Reset
REQ-030 reset=1 immediately forces state=FETCH, instr_count=0, halted=0, and the step-edge register (if present) to 0.
REQ-031 Reset overrides enable, step and any in-flight instruction, including a reset asserted during WRITEBACK; no write completes that cycle.
REQ-032 After reset deasserts, the first enabled rising edge performs FETCH.

Configuration
REQ-033 Macro MCCTRL_STEP_EN defined: an extra input step (1 bit) is added; FETCH advances only on a cycle where step has a registered rising edge (0 then 1), and ir_load is asserted only on that cycle.
REQ-034 Macro MCCTRL_STEP_EN not defined: the step port is absent and FETCH advances on every enabled cycle.

Verification
REQ-035 Scenario: reset, enable=1, instr=0x002081B3 (add x3,x1,x2) -> states 0,1,2,3; alu_control=010; alu_src=0; reg_write=1 only in cycle 4; instr_count=1.
REQ-036 Scenario: instr=0x40208133 (sub) then 0x00A0E093 (ori) -> alu_control 110 then 001; alu_src 0 then 1; instr_count=2 after 8 cycles.
REQ-037 Scenario: instr=0x00208463 (beq), zero=1 -> states 0,1,4; pc_src=1 with pc_en=1 in cycle 3; with zero=0, pc_src=0.
REQ-038 Scenario: instr=0x00000000 -> HALT after DECODE, halted=1; toggling enable leaves HALT; reset returns state=0.
REQ-039 Scenario: enable dropped during EXECUTE for 5 cycles -> state stays 2 with no pc_en or reg_write; resuming completes WRITEBACK once.
REQ-040 Scenario: MCCTRL_STEP_EN defined, step held 1 -> exactly one instruction executes; another instruction executes only after step goes 0 then 1.
